// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared opcode map, fetch state encoding and instruction width default
package fetch_pkg;

  localparam int DEF_INSTR_W = 16;

  // Opcode map shared with the control-signal decoder
  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_ILL  = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with redirect load, increment and wrapping pc+1 adder
module pc_reg #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign pc       = pc_q;

  // A redirect always wins over the sequential increment
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_plus1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: imem req/ack master, decode valid/ready source, branch redirect
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INSTR_W  = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [2:0]         if_opcode,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted,
  output logic               ill_op
);

  fetch_state_e       state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               drop_q, drop_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic               ill_q, ill_d;

  logic               pc_load;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus1;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (br_target),
    .inc      (pc_inc),
    .pc       (pc),
    .pc_plus1 (pc_plus1)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_valid    = (state_q == HOLD);
  assign halted      = (state_q == HALTED);
  assign if_instr    = instr_q;
  assign if_opcode   = instr_q[INSTR_W-1 -: 3];
  assign if_pc       = ifpc_q;
  assign if_pc_plus1 = ifpc_q + ADDR_W'(1);
  assign ill_op      = ill_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ill_d   = 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;

    case (state_q)
      FETCH: begin
        if (!req_q) begin
          // A redirect arriving in the idle cycle steers this request directly
          req_d   = 1'b1;
          addr_d  = br_taken ? br_target : pc;
          pc_load = br_taken;
        end else if (imem_ack) begin
          req_d  = 1'b0;
          drop_d = 1'b0;
          if (br_taken) begin
            pc_load = 1'b1;
          end else if (!drop_q) begin
            instr_d = imem_rdata;
            ifpc_d  = addr_q;
            pc_inc  = 1'b1;
            state_d = HOLD;
          end
        end else if (br_taken) begin
          // Request must stay stable until ack; remember to throw its data away
          pc_load = 1'b1;
          drop_d  = 1'b1;
        end
      end

      HOLD: begin
        if (br_taken) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end else if (if_ready) begin
          ill_d   = (if_opcode == OP_ILL);
          state_d = (if_opcode == OP_HALT) ? HALTED : FETCH;
        end
      end

      HALTED: begin
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      addr_q  <= '0;
      drop_q  <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that produces the 16-bit instruction, and so the 3-bit opcode, consumed by the control-signal decoder and register file.
- Owns the PC and issues one request at a time to instruction memory over a req/ack handshake.
- Hands the instruction to decode over a valid/ready handshake and accepts branch redirects from EX.
- Stops fetching after a HALT instruction.

Parameters:
ADDR_W, 8, PC / instruction-memory word-address width
RESET_PC, 0, PC value loaded at reset (ADDR_W bits)
INSTR_W, 16, instruction width; opcode is always bits [INSTR_W-1:INSTR_W-3]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  ADDR_W  word address; stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  INSTR_W  fetched instruction
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts instruction
if_instr  out  INSTR_W  instruction word
if_opcode  out  3  if_instr[15:13]
if_pc  out  ADDR_W  address of if_instr
if_pc_plus1  out  ADDR_W  if_pc+1, mod 2^ADDR_W
br_taken  in  1  redirect request, one-cycle pulse
br_target  in  ADDR_W  redirect address
halted  out  1  HALT has been delivered; fetching stopped
ill_op  out  1  one-cycle pulse when an instruction with opcode 3'b010 is accepted

Behaviour:
- Reset (async, rst_n=0) sets: pc=RESET_PC, state=FETCH, drop=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0, halted=0, ill_op=0. First imem_req rises on the first clk edge after rst_n deasserts.
- Opcode map (shared): R=000, SLTI=001, ILL=010, HALT=011, LW=100, SW=101, BEQ=110, ADDI=111.
- FETCH state:
  - imem_req=1 and imem_addr=pc, both registered and stable until ack.
  - On imem_ack with drop=0 and br_taken=0: latch rdata into if_instr, set if_pc=pc, if_valid=1 next cycle, pc<=pc+1 (wraps), go to HOLD.
  - On imem_ack with drop=1 or br_taken=1: discard rdata, clear drop, deassert imem_req for one cycle, then re-request from the updated pc.
- HOLD state:
  - imem_req=0 and if_valid=1. if_instr, if_pc and if_opcode stay stable until if_valid && if_ready.
  - On handshake of a non-HALT instruction: if_valid=0 and return to FETCH. Throughput is at most one instruction per 2 cycles plus memory latency.
  - On handshake of HALT (opcode 011): go to HALTED.
  - Opcode 010 handshake: ill_op pulses for 1 cycle; the instruction is still delivered normally.
- HALTED state: imem_req=0, if_valid=0, halted=1. Only reset exits this state; br_taken is ignored here.
- Redirect (br_taken=1) has priority over all other events in FETCH and HOLD:
  - pc<=br_target.
  - In HOLD: if_valid drops next cycle even if if_ready=1 in the same cycle. Decode must not treat that cycle as an accepted handshake, and the bench checks that it does not. Then go to FETCH.
  - In FETCH with a request outstanding and no ack this cycle: set drop=1. imem_req and imem_addr are held at the old value until ack, as the protocol requires.
  - A second br_taken while drop=1: pc updates again; the single drop flag remains sufficient.
- Wrap-around: pc=2^ADDR_W-1 increments to 0. if_pc_plus1 wraps the same way.
- Reset mid-transaction: all state is cleared immediately. Instruction memory must tolerate imem_req falling before ack.

Decomposition:
- Package fetch_pkg holds:
  - opcode localparams OP_R, OP_SLTI, OP_ILL, OP_HALT, OP_LW, OP_SW, OP_BEQ, OP_ADDI (shared with the control-signal decoder);
  - state encoding FETCH/HOLD/HALTED;
  - INSTR_W default.
- One sub-module, pc_reg: holds the PC with load (br_target), increment and reset value, plus the pc+1 adder.

Test Plan:
- Reset, memory with 1-cycle ack, 0x0000@0 and 0x8123@1, if_ready=1: imem_addr 0 then 1; if_instr 0x0000 (if_pc=0), then 0x8123 with if_opcode=100 and if_pc_plus1=2.
- Memory latency 3, if_ready=0 for 5 cycles: if_valid stays high and if_instr is stable; no new imem_req until the handshake.
- br_taken with target 0x40 two cycles into an outstanding fetch of addr 5: imem_addr stays 5 until ack; that data is never presented; next request is addr 0x40; first valid has if_pc=0x40.
- br_taken in HOLD with if_ready=1 in the same cycle: instruction is not counted as accepted; next if_pc = br_target.
- Instruction 0x6000 (HALT) at addr 3: after its handshake halted=1, imem_req stays 0 for 20 cycles, br_taken is ignored; rst_n low then high restarts at RESET_PC.
- Instruction 0x4000 accepted: ill_op high for exactly 1 cycle. With pc=0xFF, next imem_addr=0x00 and if_pc_plus1=0x00.
